// File: rtl/uart_tx.sv
// uart_tx: byte-wide to asynchronous serial transmitter.
// Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Handshake: tx_data_valid is held by upstream until acked; tx_data_ack is a
// single-cycle combinational pulse, high only while IDLE with valid present and
// reset released; tx_data is captured on the clock edge that ends the ack cycle.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ack,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, sh_n;
    logic             par_bit, par_n;
    logic             txd_n;
    logic             bit_end;

    assign bit_end = (cnt == CNT_MAX);

    // Next-state, datapath and Mealy ack; txd is derived from the next state so
    // the line changes on the same edge that enters each state.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_n       = bit_cnt;
        sh_n        = shreg;
        par_n       = par_bit;
        tx_data_ack = 1'b0;
        txd_n       = 1'b1;

        // Baud counter free-runs for the whole frame, wrapping every bit time.
        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (tx_data_valid && rst) begin
                    tx_data_ack = 1'b1;
                    sh_n        = tx_data;
                    par_n       = (^tx_data) ^ (PARITY == 2);
                    cnt_n       = '0;
                    bit_n       = '0;
                    state_n     = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    sh_n  = {1'b0, shreg[7:1]};
                    bit_n = bit_cnt + 3'd1;  // wraps to 0 after bit 7
                    if (bit_cnt == 3'd7) begin
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // bit_cnt counts the stop bits already sent.
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) state_n = S_IDLE;
                    else                      bit_n   = bit_cnt + 3'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = sh_n[0];
            S_PARITY: txd_n = par_n;
            default:  txd_n = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            txd     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            par_bit <= par_n;
            txd     <= txd_n;
            busy    <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives five transmitter configurations and compares every cycle
// of {ack, busy, txd} against a waveform built from the frame format.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [4:0] valid;
    logic [4:0] ack;
    logic [4:0] txd;
    logic [4:0] busy;
    logic [7:0] data [5];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q[$];
    logic [2:0] exp_q[$];

    int cfg_n [5] = '{4, 4, 4, 4, 3};
    int cfg_p [5] = '{0, 1, 2, 0, 2};
    int cfg_s [5] = '{1, 1, 1, 2, 2};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    // ---------------- DUTs ----------------
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_data_valid(valid[0]),
        .tx_data_ack(ack[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_data_valid(valid[1]),
        .tx_data_ack(ack[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_data_valid(valid[2]),
        .tx_data_ack(ack[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .tx_data(data[3]), .tx_data_valid(valid[3]),
        .tx_data_ack(ack[3]), .txd(txd[3]), .busy(busy[3]));
    uart_tx #(.CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .rst(rst), .tx_data(data[4]), .tx_data_valid(valid[4]),
        .tx_data_ack(ack[4]), .txd(txd[4]), .busy(busy[4]));

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Line level of frame bit j for byte b: start, data LSB first, parity, stops.
    function automatic logic frame_bit(input logic [7:0] b, input int p, input int j);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
        if (j == 0) return 1'b0;
        if (j <= 8) return logic'((b >> (j - 1)) & 1);
        if (j == 9 && p == 1) return logic'(ones % 2);
        if (j == 9 && p == 2) return logic'(1 - (ones % 2));
        return 1'b1;
    endfunction

    // Expected {ack, busy, txd} per cycle for tx_q sent with valid held high.
    task automatic build_expect(input int n, input int p, input int s);
        int nbits;
        nbits = 9 + ((p != 0) ? 1 : 0) + s;
        exp_q.delete();
        foreach (tx_q[b]) begin
            exp_q.push_back(3'b101);
            for (int j = 0; j < nbits; j++)
                for (int c = 0; c < n; c++)
                    exp_q.push_back({1'b0, 1'b1, frame_bit(tx_q[b], p, j)});
        end
        repeat (3) exp_q.push_back(3'b001);
    endtask

    // ---------------- driver ----------------
    // Releases reset (if asserted), streams tx_q into DUT k and checks every cycle.
    task automatic run_frames(input int k, input int exp_gap, input string tag);
        int idx, first_ack, second_ack;
        logic got;
        build_expect(cfg_n[k], cfg_p[k], cfg_s[k]);
        idx = 0; first_ack = -1; second_ack = -1;
        @(posedge clk); #1;
        rst = 1'b1;
        valid[k] = 1'b1;
        data[k] = tx_q[0];
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            check(tag, {29'd0, ack[k], busy[k], txd[k]}, {29'd0, exp_q[c]});
            got = ack[k];
            if (got) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
            @(posedge clk); #1;
            if (got) begin
                idx++;
                if (idx < tx_q.size()) data[k] = tx_q[idx];
                else valid[k] = 1'b0;
            end
        end
        valid[k] = 1'b0;
        if (exp_gap > 0) check({tag, ".gap"}, second_ack - first_ack, exp_gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        logic seen;
        rst = 1'b0;
        valid = 5'h1f;
        for (int k = 0; k < 5; k++) data[k] = 8'h00;

        // Reset held with valid high: line idle, no ack, not busy.
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++)
                check($sformatf("rst.%0d", k), {29'd0, ack[k], busy[k], txd[k]}, 32'h1);
        end
        valid = 5'h01;

        // Single byte straight out of reset; ack expected in first cycle.
        tx_q = '{8'hA5};
        run_frames(0, 0, "single_a5");

        tx_q = '{8'h00, 8'hFF};
        run_frames(0, 41, "b2b");

        tx_q = '{8'h07, 8'h07};
        run_frames(1, 45, "par_even");
        tx_q = '{8'h07, 8'h07};
        run_frames(2, 45, "par_odd");

        tx_q = '{8'h55, 8'h55};
        run_frames(3, 45, "stop2");

        // Randomised streams on every configuration.
        for (int k = 0; k < 5; k++) begin
            tx_q.delete();
            repeat (6) tx_q.push_back(8'($urandom_range(0, 255)));
            run_frames(k, 0, $sformatf("rand.%0d", k));
        end

        // Reset in the middle of data bit 3 of 0xF0.
        @(posedge clk); #1;
        valid[0] = 1'b1;
        data[0] = 8'hF0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 5) begin
            @(negedge clk);
            seen = ack[0];
            waited++;
        end
        check("mid.ack", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("mid.pre", {30'd0, busy[0], txd[0]}, 32'h2);
        rst = 1'b0;
        #1;
        check("mid.rst", {29'd0, ack[0], busy[0], txd[0]}, 32'h1);
        valid[0] = 1'b1;
        data[0] = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            check("mid.hold", {29'd0, ack[0], busy[0], txd[0]}, 32'h1);
        end
        tx_q = '{8'h3C};
        run_frames(0, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
